// File: rtl/sdu_pkg.sv
// Shared definitions for the serial debug unit UART transmit and receive paths:
// FSM state encoding, frame bit constants and the baud divisor helper.
package sdu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Clock cycles per bit; truncating division, callers keep the result >= 2.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sdu_uart_tx_if.sv
// Byte push handshake between debug-print logic (master) and the UART transmitter (slave).
interface sdu_uart_tx_if;
  import sdu_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sdu_sync_fifo.sv
// Generic single-clock FIFO with push/pop/full/empty/count; shared by the SDU
// transmit and receive paths. DEPTH must be a power of two so pointers wrap naturally.
module sdu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Full is judged before any same-cycle pop: a full FIFO never takes a byte.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdu_uart_tx.sv
// SDU UART transmitter: byte FIFO feeding an 8N1 serializer on txd.
// Define SDU_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module sdu_uart_tx
  import sdu_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  sdu_uart_tx_if.slave                tx_if,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  uart_state_e          state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 baud_done;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_dout;
`ifdef SDU_UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  assign baud_done = (baud_cnt == CNT_W'(DIV - 1));
  assign fifo_pop  = (state == IDLE) && !fifo_empty;

  sdu_sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_if.tx_valid),
    .din  (tx_if.tx_data),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  assign tx_if.tx_ready = !fifo_full;
  assign busy           = (state != IDLE) || (fifo_cnt != '0);

  // txd is registered from the current state, so the line trails the FSM by
  // one cycle: a pop edge puts the FSM in START and the next edge drops txd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= STOP_BIT;
`ifdef SDU_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          txd <= STOP_BIT;
          if (!fifo_empty) begin
            shift <= fifo_dout;
            state <= START;
`ifdef SDU_UART_TX_PARITY_EN
            parity_bit <= ^fifo_dout;
`endif
          end
        end

        START: begin
          txd <= START_BIT;
          if (baud_done) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end

        DATA: begin
          txd <= shift[0];
          if (baud_done) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef SDU_UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef SDU_UART_TX_PARITY_EN
        PARITY: begin
          txd <= parity_bit;
          if (baud_done) state <= STOP;
        end
`endif

        STOP: begin
          txd <= STOP_BIT;
          if (baud_done) state <= IDLE;
        end

        default: begin
          txd   <= STOP_BIT;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdu_uart_tx.sv
// Self-checking bench for sdu_uart_tx: a queue/timing model checked every cycle,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_sdu_uart_tx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 16;
  localparam int DIV      = 16;
  localparam int CW       = $clog2(DEPTH) + 1;
`ifdef SDU_UART_TX_PARITY_EN
  localparam int NB         = 11;
  localparam int EXP_PERIOD = 177;
  localparam logic [10:0] EXP_55_SAMPLES = 11'b100_1010_1010;
`else
  localparam int NB         = 10;
  localparam int EXP_PERIOD = 161;
  localparam logic [10:0] EXP_55_SAMPLES = 11'b010_1010_1010;
`endif
  localparam int FRAME = NB * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic          txd;
  logic          busy;
  logic [CW-1:0] fifo_cnt;

  sdu_uart_tx_if tx_if ();

  sdu_uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_if   (tx_if),
    .txd     (txd),
    .busy    (busy),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line image of one frame, index k = bit slot on the wire (start first).
  function automatic logic [10:0] make_frame(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef SDU_UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Reference model: byte queue plus the edge at which the current frame was
  // popped; the line value is a pure function of elapsed cycles since that pop.
  logic [7:0]  mq[$];
  logic [10:0] frame_bits = '1;
  int          frame_pop  = 0;
  int          next_free  = 0;
  bit          frame_active = 0;
  bit          model_on     = 0;

  initial begin : model_proc
    int   pre;
    int   k;
    bit   pop_now;
    bit   push_now;
    logic exp_txd;
    logic exp_busy;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst === 1'b1) begin
        mq.delete();
        frame_active = 0;
        next_free    = cyc + 1;
        model_on     = 1;
      end else if (model_on) begin
        pre      = mq.size();
        pop_now  = (cyc >= next_free) && (pre > 0);
        push_now = (tx_if.tx_valid === 1'b1) && (pre < DEPTH);
        if (pop_now) begin
          frame_bits   = make_frame(mq.pop_front());
          frame_pop    = cyc;
          frame_active = 1;
          next_free    = cyc + FRAME + 1;
        end
        if (push_now) mq.push_back(tx_if.tx_data);
      end
      @(negedge clk);
      if (model_on) begin
        k        = cyc - frame_pop - 1;
        exp_txd  = (frame_active && k >= 0 && k < FRAME) ? frame_bits[k / DIV] : 1'b1;
        exp_busy = (mq.size() != 0) || (frame_active && cyc < frame_pop + FRAME);
        check("model_txd", 32'(txd), 32'(exp_txd));
        check("model_busy", 32'(busy), 32'(exp_busy));
        check("model_tx_ready", 32'(tx_if.tx_ready), 32'(mq.size() < DEPTH));
        check("model_fifo_cnt", 32'(fifo_cnt), mq.size());
      end
    end
  end

  task automatic push_one(input logic [7:0] b);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = b;
    @(posedge clk); #1;
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    check("wait_idle", 32'(busy), 0);
  endtask

  // Independent line decoder: finds the start edge, then samples mid-bit.
  task automatic decode(output logic [7:0] b, output logic par, output int t_fall);
    bit found;
    found  = 0;
    b      = '0;
    par    = 1'b0;
    t_fall = 0;
    for (int i = 0; i < 4 * FRAME && !found; i++) begin
      @(posedge clk); #1;
      if (txd === 1'b0) found = 1;
    end
    if (!found) begin
      check("decode_start_timeout", 0, 1);
      return;
    end
    t_fall = cyc;
    repeat (DIV / 2) @(posedge clk);
    #1;
    check("decode_start_bit", 32'(txd), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk);
      #1;
      b[i] = txd;
    end
`ifdef SDU_UART_TX_PARITY_EN
    repeat (DIV) @(posedge clk);
    #1;
    par = txd;
    check("decode_parity", 32'(par), 32'(^b));
`endif
    repeat (DIV) @(posedge clk);
    #1;
    check("decode_stop_bit", 32'(txd), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        p;
    int          t0;
    int          t1;
    logic [10:0] exp55;

    rst            = 1'b1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hC3;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", 32'(txd), 1);
    check("reset_tx_ready", 32'(tx_if.tx_ready), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_fifo_cnt", 32'(fifo_cnt), 0);
    rst            = 1'b0;
    tx_if.tx_valid = 1'b0;
    @(posedge clk); #1;
    check("reset_nothing_queued", 32'(fifo_cnt), 0);

    // Single byte 0x55 into an idle block.
    push_one(8'h55);
    t0 = cyc;
    check("single_cnt", 32'(fifo_cnt), 1);
    for (int i = 0; i < 8 && txd !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    check("single_latency", cyc - t0, 2);
    exp55 = EXP_55_SAMPLES;
    for (int k = 0; k < NB; k++) begin
      repeat ((k == 0) ? 8 : 16) @(posedge clk);
      #1;
      check("single_bit", 32'(txd), 32'(exp55[k]));
    end
    for (int i = 0; i < 400 && busy !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    check("single_busy_len", cyc - t0, EXP_PERIOD);

    // Back-to-back: the second push lands on the pop edge of the first byte,
    // so occupancy holds at 1 before draining to 0.
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h41;
    @(posedge clk); #1;
    check("b2b_cnt_first", 32'(fifo_cnt), 1);
    tx_if.tx_data = 8'h0A;
    @(posedge clk); #1;
    tx_if.tx_valid = 1'b0;
    check("b2b_cnt_second", 32'(fifo_cnt), 1);
    decode(b0, p, t0);
    check("b2b_cnt_between", 32'(fifo_cnt), 1);
    decode(b1, p, t1);
    check("b2b_byte0", 32'(b0), 32'h41);
    check("b2b_byte1", 32'(b1), 32'h0A);
    check("b2b_period", t1 - t0, EXP_PERIOD);
    check("b2b_cnt_drained", 32'(fifo_cnt), 0);
    wait_idle(4 * FRAME);

    // Full FIFO: hold the FSM with an in-flight frame, then push 17 bytes.
    fork
      begin
        push_one(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
          tx_if.tx_valid = 1'b1;
          tx_if.tx_data  = i[7:0];
          @(posedge clk); #1;
          if (i == 15) begin
            check("full_cnt", 32'(fifo_cnt), 16);
            check("full_ready", 32'(tx_if.tx_ready), 0);
          end
        end
        tx_if.tx_valid = 1'b0;
        check("full_drop_cnt", 32'(fifo_cnt), 16);
      end
      begin
        for (int j = 0; j < 17; j++) begin
          decode(b0, p, t0);
          check("full_stream", 32'(b0), (j == 0) ? 32'hA5 : 32'(j - 1));
        end
      end
    join
    wait_idle(4 * FRAME);

    // Reset during DATA bit 3 of 0xFF with another byte queued behind it.
    push_one(8'hFF);
    push_one(8'h77);
    for (int i = 0; i < 8 && txd !== 1'b0; i++) begin
      @(posedge clk); #1;
    end
    repeat (8 + 4 * DIV) @(posedge clk);
    #1;
    check("rst_mid_pre_cnt", 32'(fifo_cnt), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_txd", 32'(txd), 1);
    check("rst_mid_cnt", 32'(fifo_cnt), 0);
    check("rst_mid_busy", 32'(busy), 0);
    push_one(8'h33);
    decode(b0, p, t0);
    check("rst_mid_after", 32'(b0), 32'h33);
    wait_idle(4 * FRAME);

`ifdef SDU_UART_TX_PARITY_EN
    push_one(8'h07);
    decode(b0, p, t0);
    check("par_07_byte", 32'(b0), 32'h07);
    check("par_07_bit", 32'(p), 1);
    wait_idle(4 * FRAME);
    push_one(8'h03);
    decode(b0, p, t0);
    check("par_03_bit", 32'(p), 0);
    wait_idle(4 * FRAME);
`endif

    // Randomized traffic: sparse then dense, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      tx_if.tx_valid = ($urandom_range(0, 99) < 2);
      tx_if.tx_data  = 8'($urandom);
      rst            = ($urandom_range(0, 1499) == 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3000; i++) begin
      tx_if.tx_valid = ($urandom_range(0, 1) == 1);
      tx_if.tx_data  = 8'($urandom);
      rst            = ($urandom_range(0, 1999) == 0);
      @(posedge clk); #1;
    end
    rst            = 1'b0;
    tx_if.tx_valid = 1'b0;
    wait_idle((DEPTH + 2) * (FRAME + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
